// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Every serial operator uses the same IDLE/RUN/DONE sequencing.
package serial_arith_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t IDLE = 2'b00;
  localparam fsm_state_t RUN  = 2'b01;
  localparam fsm_state_t DONE = 2'b10;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell used by the serial datapath.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first,
// with a valid/ready handshake on both operand and result sides.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  fsm_state_t       state_r;
  fsm_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic             br_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             d_s;
  logic             br_nxt_s;
  logic             accept_s;
  logic             last_s;

  // in_ready_r also gates acceptance so nothing is taken in the cycle after reset
  assign accept_s = (state_r == IDLE) && in_valid && in_ready_r;
  assign last_s   = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));

  full_subtractor u_cell (
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (br_nxt_s)
  );

  // Next-state decode for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered handshake flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand shifters, borrow flop, result shifter and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      diff_r <= {WIDTH{1'b0}};
      br_r   <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_sh_r <= a;
      b_sh_r <= b;
      br_r   <= bin;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
      // difference bits enter at the top so bit 0 ends at diff[0]
      diff_r <= {d_s, diff_r[WIDTH-1:1]};
      br_r   <= br_nxt_s;
      cnt_r  <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end else begin
      a_sh_r <= a_sh_r;
      b_sh_r <= b_sh_r;
      diff_r <= diff_r;
      br_r   <= br_r;
      cnt_r  <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = br_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16,
// directed corner cases plus randomized back-to-back traffic.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic        iv8, rdy8, bin8, ov8, ordy8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        iv16, rdy16, bin16, ov16, ordy16, bout16;
  logic [15:0] a16, b16, diff16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(ordy8),
    .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
    .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(ordy16),
    .diff(diff16), .bout(bout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; bout is the sign of the true result
  function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic bi);
    int t;
    logic [15:0] m;
    t = int'(a) - int'(b) - int'(bi);
    m = (w == 16) ? 16'hFFFF : 16'h00FF;
    return {(t < 0) ? 1'b1 : 1'b0, 16'(t) & m};
  endfunction

  function automatic logic [15:0] get_diff(input int w);
    return (w == 8) ? {8'h00, diff8} : diff16;
  endfunction
  function automatic logic get_bout(input int w);
    return (w == 8) ? bout8 : bout16;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction
  function automatic logic get_rdy(input int w);
    return (w == 8) ? rdy8 : rdy16;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic bi);
    if (w == 8) begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0]; bin8 = bi;
    end else begin
      iv16 = v; a16 = a; b16 = b; bin16 = bi;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 8) ordy8 = r;
    else        ordy16 = r;
  endtask

  // Present one operand set and return at the negedge after the accepting edge
  task automatic start(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input string tag);
    int n;
    n = 0;
    while (!get_rdy(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 32'(get_rdy(w)), 32'd1);
    set_in(w, 1'b1, a, b, bi);
    @(negedge clk);
    acc_cyc = cyc;
    set_in(w, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Wait for out_valid; latency counts the accepting edge as cycle 1
  task automatic wait_done(input int w, input string tag);
    int n;
    n = 0;
    while (!get_ov(w) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(w + 1));
  endtask

  task automatic check_res(input int w, input logic [15:0] a, input logic [15:0] b,
                           input logic bi, input string tag);
    logic [16:0] e;
    e = model(w, a, b, bi);
    chk({tag, "_out_valid"}, 32'(get_ov(w)), 32'd1);
    chk({tag, "_diff"}, 32'(get_diff(w)), 32'(e[15:0]));
    chk({tag, "_bout"}, 32'(get_bout(w)), 32'(e[16]));
  endtask

  task automatic release_res(input int w, input string tag);
    set_ordy(w, 1'b1);
    @(negedge clk);
    set_ordy(w, 1'b0);
    chk({tag, "_in_ready_after"}, 32'(get_rdy(w)), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(get_ov(w)), 32'd0);
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input string tag);
    start(w, a, b, bi, tag);
    wait_done(w, tag);
    check_res(w, a, b, bi, tag);
    release_res(w, tag);
  endtask

  // Back-to-back random operands with out_ready held high; checks results and period
  task automatic rand_stream(input int w, input int n);
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] m, ra, rb;
    logic        rbi;
    int got, guard, last_rise;
    m = (w == 16) ? 16'hFFFF : 16'h00FF;
    got = 0;
    guard = 0;
    last_rise = -1;
    set_ordy(w, 1'b1);
    while (got < n && guard < n * (w + 2) + 60) begin
      @(negedge clk);
      guard++;
      if (get_ov(w)) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_diff", 32'(get_diff(w)), 32'(e[15:0]));
          chk("rand_bout", 32'(get_bout(w)), 32'(e[16]));
        end
        if (last_rise >= 0) chk("rand_period", 32'(cyc - last_rise), 32'(w + 2));
        last_rise = cyc;
        got++;
      end
      ra = 16'($urandom) & m;
      rb = 16'($urandom) & m;
      rbi = 1'($urandom);
      if (($urandom % 8) == 0) rb = ra;
      set_in(w, 1'b1, ra, rb, rbi);
      if (get_rdy(w)) q.push_back(model(w, ra, rb, rbi));
    end
    chk("rand_result_count", 32'(got), 32'(n));
    set_in(w, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    set_ordy(w, 1'b0);
    chk("rand_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    set_in(8, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_in(16, 1'b0, 16'h0000, 16'h0000, 1'b0);
    ordy8 = 1'b0;
    ordy16 = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 32'(rdy8), 32'd0);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    chk("rst_in_ready16", 32'(rdy16), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 32'(rdy8), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_after_edge", 32'(rdy8), 32'd1);
    chk("rel_in_ready16_after_edge", 32'(rdy16), 32'd1);

    run_op(8, 16'h005A, 16'h0023, 1'b0, "basic");
    run_op(8, 16'h0000, 16'h0001, 1'b0, "wrap");
    run_op(8, 16'h0010, 16'h0010, 1'b1, "eq_bin");
    run_op(8, 16'h00FF, 16'h0000, 1'b1, "max");
    run_op(16, 16'h1234, 16'hABCD, 1'b1, "w16");

    // Result held while out_ready stays low
    start(8, 16'h00C3, 16'h005E, 1'b1, "hold");
    wait_done(8, "hold");
    for (int i = 0; i < 5; i++) begin
      check_res(8, 16'h00C3, 16'h005E, 1'b1, "hold");
      chk("hold_in_ready", 32'(rdy8), 32'd0);
      @(negedge clk);
    end
    check_res(8, 16'h00C3, 16'h005E, 1'b1, "hold_end");
    release_res(8, "hold");

    // A second operand set offered mid-RUN must be ignored
    start(8, 16'h005A, 16'h0023, 1'b0, "ign");
    @(negedge clk);
    set_in(8, 1'b1, 16'h00FF, 16'h0000, 1'b0);
    @(negedge clk);
    set_in(8, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_done(8, "ign");
    check_res(8, 16'h005A, 16'h0023, 1'b0, "ign");
    release_res(8, "ign");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("ign_no_second_result", 32'(seen), 32'd0);

    // Reset during RUN discards the operation
    start(8, 16'h005A, 16'h0023, 1'b0, "midrst");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_bout", 32'(bout8), 32'd0);
    chk("midrst_out_valid", 32'(ov8), 32'd0);
    chk("midrst_in_ready", 32'(rdy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("midrst_no_out_valid", 32'(seen), 32'd0);
    run_op(8, 16'h0080, 16'h007F, 1'b0, "after_rst");

    rand_stream(8, 40);
    rand_stream(16, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 2..32.
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 Port in_valid, input, 1, operands a, b and bin are presented.
REQ-005 Port in_ready, output, 1, the block can accept operands.
REQ-006 Port a, input, WIDTH, the minuend.
REQ-007 Port b, input, WIDTH, the subtrahend.
REQ-008 Port bin, input, 1, borrow-in applied to bit 0.
REQ-009 Port out_valid, output, 1, the result is available.
REQ-010 Port out_ready, input, 1, the consumer accepts the result.
REQ-011 Port diff, output, WIDTH, the result (a - b - bin) mod 2^WIDTH.
REQ-012 Port bout, output, 1, borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 In IDLE, when in_valid is 1 the block SHALL latch a, b and bin into internal shift registers and a borrow flop, and enter RUN.
REQ-016 On each RUN cycle, the block SHALL subtract exactly one bit, LSB first, with one full-subtractor cell:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
REQ-017 On each RUN cycle, the block SHALL shift the difference bit into the result register MSB-first-fill, so that the LSB lands at diff[0] after WIDTH shifts.
REQ-018 A bit counter SHALL count 0..WIDTH-1 in RUN; on the cycle it equals WIDTH-1, the FSM SHALL go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge of in_valid.
REQ-020 In DONE, out_valid SHALL be 1, and diff and bout SHALL be held stable until out_ready is sampled 1.
REQ-021 In DONE with out_ready = 1, the FSM SHALL return to IDLE on that edge; in_ready SHALL be 1 on the next cycle.
REQ-022 out_valid SHALL be 0 in IDLE and RUN.
REQ-023 in_valid and input data changes while in RUN or DONE SHALL be ignored, with no effect on the in-flight result.
REQ-024 Underflow SHALL wrap:
  - a < b + bin: diff wraps modulo 2^WIDTH and bout = 1
  - a = b with bin = 1: diff = all ones, bout = 1
REQ-025 out_ready held high continuously SHALL give a throughput of one result per WIDTH+2 cycles.
REQ-026 diff and bout SHALL come directly from registers, with no combinational path from inputs.

Reset
REQ-027 While rst_n = 0, the block SHALL asynchronously force:
  - FSM = IDLE, counter = 0, borrow flop = 0
  - shift and result registers = 0
  - out_valid = 0, diff = 0, bout = 0
REQ-028 in_ready SHALL be 0 while rst_n = 0, and 1 from the first clock edge after rst_n deasserts.
REQ-029 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Structure
REQ-030 The FSM state encoding type and the IDLE/RUN/DONE constants SHALL live in the shared package serial_arith_pkg, for reuse by a later serial adder.
REQ-031 The per-bit logic SHALL be the combinational sub-module full_subtractor, with ports x, y, bin, d, bout, instantiated once.
REQ-032 The counter width SHALL be $clog2(WIDTH).

Verification
REQ-033 WIDTH=8, a=0x5A, b=0x23, bin=0 -> after 9 cycles: out_valid=1, diff=0x37, bout=0.
REQ-034 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; and a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid, diff and bout stay constant; out_ready=1 -> IDLE, and in_ready=1 next cycle.
REQ-036 in_valid pulsed with a=0xFF, b=0x00 during RUN of 0x5A-0x23 -> result still 0x37; the second operand set is not accepted.
REQ-037 rst_n pulsed low at RUN cycle 4 -> outputs are zero immediately and no out_valid follows; a fresh 0x80-0x7F then gives diff=0x01, bout=0.
REQ-038 Random back-to-back operands with a reference model, for WIDTH=8 and WIDTH=16 -> every diff and bout matches (a - b - bin) mod 2^WIDTH.
